// File: rtl/mac_pkg.sv
// Shared MAC datapath types: operand width, accumulator width and the
// operand pair carried through the operand FIFO.
package mac_pkg;

  localparam int DATA_W = 10;
  localparam int ACC_W  = 20;

  typedef struct packed {
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/mac_fifo_mem.sv
// Operand-pair storage for mac_operand_fifo: DEPTH register entries,
// one synchronous write port, one asynchronous read port, no reset
// (entries carry no meaning until written).
module mac_fifo_mem
  import mac_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [PTR_W-1:0]     wr_addr,
  input  operand_pair_t        wr_data,
  input  logic [PTR_W-1:0]     rd_addr,
  output operand_pair_t        rd_data
);

  operand_pair_t mem [DEPTH];

  // Write the tail entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mac_operand_fifo.sv
// First-word-fall-through operand-pair FIFO in front of the MAC.
// Pointers, occupancy and valid/ready handshake live here; storage is
// mac_fifo_mem. WIDTH is expected to match mac_pkg::DATA_W.
// Optional macro MAC_FIFO_LEVEL_EN adds the registered occupancy port
// 'level'.
module mac_operand_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] b_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic signed [WIDTH-1:0] a_out,
  output logic signed [WIDTH-1:0] b_out,
  output logic                    valid_out,
  input  logic                    ready_in
`ifdef MAC_FIFO_LEVEL_EN
  ,
  output logic [PTR_W:0]          level
`endif
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  operand_pair_t    wr_pair;
  operand_pair_t    rd_pair;

  // Handshake flags come only from registered occupancy; a full FIFO
  // refuses a push even when a pop happens on the same edge.
  assign ready_out = (count != FULL_CNT);
  assign valid_out = (count != '0);
  assign push      = valid_in & ready_out;
  assign pop       = valid_out & ready_in;

  assign wr_pair.a = a_in;
  assign wr_pair.b = b_in;
  assign a_out     = rd_pair.a;
  assign b_out     = rd_pair.b;

`ifdef MAC_FIFO_LEVEL_EN
  assign level = count;
`endif

  // Advance pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  mac_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_pair),
    .rd_addr (rd_ptr),
    .rd_data (rd_pair)
  );

endmodule

// File: tb/tb_mac_operand_fifo.sv
// Directed bench for mac_operand_fifo (DEPTH=8, WIDTH=10). Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_mac_operand_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 10;

  logic                    clk;
  logic                    reset;
  logic signed [WIDTH-1:0] a_in;
  logic signed [WIDTH-1:0] b_in;
  logic                    valid_in;
  logic                    ready_out;
  logic signed [WIDTH-1:0] a_out;
  logic signed [WIDTH-1:0] b_out;
  logic                    valid_out;
  logic                    ready_in;
`ifdef MAC_FIFO_LEVEL_EN
  logic [3:0]              level;
`endif

  int total = 0;
  int bad   = 0;

  mac_operand_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a_in      (a_in),
    .b_in      (b_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .a_out     (a_out),
    .b_out     (b_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
`ifdef MAC_FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=hang required=finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    #2;
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL reset_valid_async: actual=%b required=0", valid_out);
    end
    total++;
    if (ready_out !== 1'b1) begin
      bad++; $display("FAIL reset_ready_async: actual=%b required=1", ready_out);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL idle_valid: actual=%b required=0", valid_out);
    end
    total++;
    if (ready_out !== 1'b1) begin
      bad++; $display("FAIL idle_ready: actual=%b required=1", ready_out);
    end
`ifdef MAC_FIFO_LEVEL_EN
    total++;
    if (level !== 4'd0) begin
      bad++; $display("FAIL idle_level: actual=%0d required=0", level);
    end
`endif
  endtask

  task automatic test_single();
    int prod;
    a_in     = -10'sd3;
    b_in     = 10'sd7;
    valid_in = 1'b1;
    ready_in = 1'b1;
    #1;
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL single_no_bypass: actual=%b required=0", valid_out);
    end
    @(negedge clk);
    valid_in = 1'b0;
    total++;
    if (valid_out !== 1'b1 || a_out !== -10'sd3 || b_out !== 10'sd7) begin
      bad++; $display("FAIL single_head: actual=v%b a=%0d b=%0d required=v1 a=-3 b=7",
                      valid_out, a_out, b_out);
    end
    prod = int'(a_out) * int'(b_out);
    total++;
    if (prod !== -21) begin
      bad++; $display("FAIL single_mac_f: actual=%0d required=-21", prod);
    end
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL single_one_cycle: actual=%b required=0", valid_out);
    end
  endtask

  task automatic test_fill();
    logic signed [WIDTH-1:0] ea, eb;
    ready_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      a_in     = WIDTH'(i);
      b_in     = WIDTH'(-i);
      valid_in = 1'b1;
      @(negedge clk);
    end
    total++;
    if (ready_out !== 1'b0 || valid_out !== 1'b1) begin
      bad++; $display("FAIL fill_full: actual=r%b v%b required=r0 v1", ready_out, valid_out);
    end
`ifdef MAC_FIFO_LEVEL_EN
    total++;
    if (level !== 4'd8) begin
      bad++; $display("FAIL fill_level: actual=%0d required=8", level);
    end
`endif
    a_in = 10'sd99;
    b_in = 10'sd99;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (ready_out !== 1'b0) begin
      bad++; $display("FAIL fill_refuse: actual=%b required=0", ready_out);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      ea = WIDTH'(i);
      eb = WIDTH'(-i);
      total++;
      if (valid_out !== 1'b1 || a_out !== ea || b_out !== eb) begin
        bad++; $display("FAIL fill_drain_%0d: actual=v%b a=%0d b=%0d required=v1 a=%0d b=%0d",
                        i, valid_out, a_out, b_out, ea, eb);
      end
      @(negedge clk);
    end
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL fill_empty_after: actual=%b required=0", valid_out);
    end
  endtask

  task automatic test_full_pop();
    logic signed [WIDTH-1:0] ea, eb;
    ready_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      a_in     = WIDTH'(10 + i);
      b_in     = WIDTH'(i);
      valid_in = 1'b1;
      @(negedge clk);
    end
    a_in     = 10'sd55;
    b_in     = -10'sd55;
    ready_in = 1'b1;
    @(negedge clk);
    total++;
    if (ready_out !== 1'b1 || a_out !== 10'sd12) begin
      bad++; $display("FAIL fullpop_occ7: actual=r%b head=%0d required=r1 head=12", ready_out, a_out);
    end
`ifdef MAC_FIFO_LEVEL_EN
    total++;
    if (level !== 4'd7) begin
      bad++; $display("FAIL fullpop_level: actual=%0d required=7", level);
    end
`endif
    ready_in = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    total++;
    if (ready_out !== 1'b0) begin
      bad++; $display("FAIL fullpop_refill: actual=%b required=0", ready_out);
    end
    ready_in = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      ea = (i == 9) ? 10'sd55 : WIDTH'(10 + i);
      eb = (i == 9) ? -10'sd55 : WIDTH'(i);
      total++;
      if (valid_out !== 1'b1 || a_out !== ea || b_out !== eb) begin
        bad++; $display("FAIL fullpop_drain_%0d: actual=v%b a=%0d b=%0d required=v1 a=%0d b=%0d",
                        i, valid_out, a_out, b_out, ea, eb);
      end
      @(negedge clk);
    end
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL fullpop_empty_after: actual=%b required=0", valid_out);
    end
  endtask

  task automatic test_wrap();
    logic signed [WIDTH-1:0] va [20];
    logic signed [WIDTH-1:0] vb [20];
    logic signed [2*WIDTH-1:0] q [$];
    logic signed [2*WIDTH-1:0] exp_pair;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    va[0] = -10'sd512; vb[0] = 10'sd511;
    va[1] = 10'sd511;  vb[1] = -10'sd512;
    for (int i = 2; i < 20; i++) begin
      va[i] = WIDTH'(i * 37 - 300);
      vb[i] = WIDTH'(200 - i * 23);
    end
    while ((sent < 20 || got < 20) && cyc < 300) begin
      valid_in = (sent < 20);
      a_in     = (sent < 20) ? va[sent] : '0;
      b_in     = (sent < 20) ? vb[sent] : '0;
      ready_in = cyc[0];
      #1;
      total++;
      if (valid_out !== (q.size() != 0) || ready_out !== (q.size() < DEPTH)) begin
        bad++; $display("FAIL wrap_flags_c%0d: actual=v%b r%b required=v%b r%b", cyc,
                        valid_out, ready_out, q.size() != 0, q.size() < DEPTH);
      end
      if (valid_out && ready_in) begin
        exp_pair = q.pop_front();
        total++;
        if ({a_out, b_out} !== exp_pair) begin
          bad++; $display("FAIL wrap_data_%0d: actual=a%0d b%0d required=a%0d b%0d", got,
                          a_out, b_out, $signed(exp_pair[2*WIDTH-1:WIDTH]),
                          $signed(exp_pair[WIDTH-1:0]));
        end
        got++;
      end
      if (valid_in && ready_out) begin
        q.push_back({va[sent], vb[sent]});
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    valid_in = 1'b0;
    total++;
    if (got != 20 || sent != 20) begin
      bad++; $display("FAIL wrap_timeout: actual=sent%0d got%0d required=sent20 got20", sent, got);
    end
  endtask

  task automatic test_mid_reset();
    ready_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      a_in     = WIDTH'(i);
      b_in     = WIDTH'(i);
      valid_in = 1'b1;
      @(negedge clk);
    end
    valid_in = 1'b0;
    total++;
    if (valid_out !== 1'b1) begin
      bad++; $display("FAIL midrst_queued: actual=%b required=1", valid_out);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      bad++; $display("FAIL midrst_async: actual=v%b r%b required=v0 r1", valid_out, ready_out);
    end
    #2 reset = 1'b1;
    @(negedge clk);
    a_in     = 10'sd4;
    b_in     = 10'sd4;
    valid_in = 1'b1;
    ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    total++;
    if (valid_out !== 1'b1 || a_out !== 10'sd4 || b_out !== 10'sd4) begin
      bad++; $display("FAIL midrst_first: actual=v%b a=%0d b=%0d required=v1 a=4 b=4",
                      valid_out, a_out, b_out);
    end
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL midrst_empty_after: actual=%b required=0", valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
